// File: rtl/frac_clk_gen.sv
// Multi-channel fractional clock-enable generator: each channel is a phase
// accumulator whose carry-out is a registered one-cycle enable pulse.
module frac_clk_gen #(
   parameter int          CHANNELS    = 2,
   parameter int          ACC_WIDTH   = 32,
   parameter int          PHASE_BITS  = 8,
   parameter logic [31:0] DEFAULT_INC = 32'h0000_0000,
   parameter int          LOCK_CYCLES = 16,
   localparam int         SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                           clkin,
   input  logic                           reset_n,
   input  logic                           enable,
   input  logic                           phase_clr,
   input  logic                           inc_wr,
   input  logic [SEL_W-1:0]               inc_sel,
   input  logic [ACC_WIDTH-1:0]           inc_data,
   output logic [CHANNELS-1:0]            ce_out,
   output logic [CHANNELS*PHASE_BITS-1:0] phase_out,
   output logic [CHANNELS-1:0]            pending,
   output logic                           lock
);

   localparam int                   CNT_W    = $clog2(LOCK_CYCLES + 1);
   localparam logic [ACC_WIDTH-1:0] INIT_INC = DEFAULT_INC[ACC_WIDTH-1:0];
   localparam logic [CNT_W-1:0]     LOCK_MAX = CNT_W'(LOCK_CYCLES);

   logic [CHANNELS-1:0][ACC_WIDTH-1:0] acc_q,  acc_d;
   logic [CHANNELS-1:0][ACC_WIDTH-1:0] inc_q,  inc_d;
   logic [CHANNELS-1:0][ACC_WIDTH-1:0] pval_q, pval_d;
   logic [CHANNELS-1:0]                pend_q, pend_d;
   logic [CHANNELS-1:0]                ce_q,   ce_d;
   logic [CNT_W-1:0]                   lcnt_q, lcnt_d;
   logic [CHANNELS-1:0]                apply;

   always_comb begin
      logic [ACC_WIDTH:0] sum;
      logic               wr_hit;
      sum    = '0;
      wr_hit = 1'b0;
      acc_d  = acc_q;
      inc_d  = inc_q;
      pval_d = pval_q;
      pend_d = pend_q;
      ce_d   = '0;
      apply  = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         sum    = {1'b0, acc_q[i]} + {1'b0, inc_q[i]};
         wr_hit = inc_wr && (int'(inc_sel) == i);
         // A stalled or zero-rate channel never carries, so it takes the new rate at once;
         // a running one switches only on its carry so the current period completes.
         apply[i] = pend_q[i] && (!enable || (inc_q[i] == '0) ||
                                  (sum[ACC_WIDTH] && !phase_clr));
         if (apply[i]) begin
            inc_d[i]  = pval_q[i];
            pend_d[i] = 1'b0;
         end
         if (wr_hit) begin
            pval_d[i] = inc_data;
            pend_d[i] = 1'b1;
         end
         if (phase_clr) begin
            acc_d[i] = '0;
         end else if (enable) begin
            acc_d[i] = sum[ACC_WIDTH-1:0];
            ce_d[i]  = sum[ACC_WIDTH];
         end
      end
   end

   always_comb begin
      lcnt_d = lcnt_q;
      if (!enable || (|apply)) begin
         lcnt_d = '0;
      end else if (lcnt_q != LOCK_MAX) begin
         lcnt_d = lcnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         acc_q  <= '0;
         inc_q  <= {CHANNELS{INIT_INC}};
         pval_q <= '0;
         pend_q <= '0;
         ce_q   <= '0;
         lcnt_q <= '0;
      end else begin
         acc_q  <= acc_d;
         inc_q  <= inc_d;
         pval_q <= pval_d;
         pend_q <= pend_d;
         ce_q   <= ce_d;
         lcnt_q <= lcnt_d;
      end
   end

   for (genvar g = 0; g < CHANNELS; g++) begin : g_phase
      assign phase_out[g*PHASE_BITS +: PHASE_BITS] = acc_q[g][ACC_WIDTH-1 -: PHASE_BITS];
   end

   assign ce_out  = ce_q;
   assign pending = pend_q;
   assign lock    = (lcnt_q == LOCK_MAX) && !(|pend_q);

endmodule

// File: tb/tb_frac_clk_gen.sv
// Directed bench for frac_clk_gen with 4-bit accumulators, two channels and
// a default increment of 4; expected values are worked out by hand per edge.
module tb_frac_clk_gen;

   localparam int CH = 2;
   localparam int AW = 4;
   localparam int PB = 4;
   localparam int LC = 4;

   logic           clkin = 1'b0;
   logic           reset_n;
   logic           enable;
   logic           phase_clr;
   logic           inc_wr;
   logic [0:0]     inc_sel;
   logic [AW-1:0]  inc_data;
   logic [CH-1:0]  ce_out;
   logic [CH*PB-1:0] phase_out;
   logic [CH-1:0]  pending;
   logic           lock;

   int checks = 0;
   int errors = 0;
   int pulses = 0;

   always #5 clkin = ~clkin;

   frac_clk_gen #(
      .CHANNELS   (CH),
      .ACC_WIDTH  (AW),
      .PHASE_BITS (PB),
      .DEFAULT_INC(32'h0000_0004),
      .LOCK_CYCLES(LC)
   ) dut (
      .clkin    (clkin),
      .reset_n  (reset_n),
      .enable   (enable),
      .phase_clr(phase_clr),
      .inc_wr   (inc_wr),
      .inc_sel  (inc_sel),
      .inc_data (inc_data),
      .ce_out   (ce_out),
      .phase_out(phase_out),
      .pending  (pending),
      .lock     (lock)
   );

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clkin);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; phase_clr = 1'b0;
      inc_wr = 1'b0; inc_sel = 1'b0; inc_data = '0;
      tick(2);
      chk("rst_ce", ce_out, 0);
      chk("rst_phase", phase_out, 0);
      chk("rst_pending", pending, 0);
      chk("rst_lock", lock, 0);

      // default increment 4: period 4, phase 4,8,12,0
      reset_n = 1'b1; enable = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         chk("inc4_phase0", phase_out[3:0], (4 * k) % 16);
         chk("inc4_phase1", phase_out[7:4], (4 * k) % 16);
         chk("inc4_ce0", ce_out[0], (k % 4) == 0);
         if (k == 3) chk("lock_early", lock, 0);
         if (k == 4) chk("lock_rise", lock, 1);
      end

      // rate change 4 -> 2 written at acc=4
      tick();
      chk("pre_wr_phase0", phase_out[3:0], 4);
      inc_wr = 1'b1; inc_sel = 1'b0; inc_data = 4'd2;
      tick();
      inc_wr = 1'b0;
      chk("pend_set", pending, 2'b01);
      chk("pend_lock_low", lock, 0);
      chk("pend_phase0", phase_out[3:0], 8);
      tick();
      chk("pend_hold", pending, 2'b01);
      chk("old_rate_phase0", phase_out[3:0], 12);
      chk("old_rate_no_ce", ce_out[0], 0);
      tick();
      chk("carry_ce", ce_out[0], 1);
      chk("carry_phase0", phase_out[3:0], 0);
      chk("pend_clear", pending, 2'b00);
      chk("apply_lock_low", lock, 0);
      for (int k = 13; k <= 20; k++) begin
         tick();
         chk("inc2_phase0", phase_out[3:0], (2 * (k - 12)) % 16);
         chk("inc2_ce0", ce_out[0], k == 20);
         if (k == 15) chk("relock_early", lock, 0);
         if (k == 16) chk("relock", lock, 1);
      end

      // channel 1: 6 then 2 while pending; 5 written on the applying cycle
      inc_wr = 1'b1; inc_sel = 1'b1; inc_data = 4'd6;
      tick();
      chk("ch1_pend", pending, 2'b10);
      inc_data = 4'd2;
      tick();
      inc_wr = 1'b0;
      tick();
      chk("ch1_phase_e23", phase_out[7:4], 12);
      inc_wr = 1'b1; inc_sel = 1'b1; inc_data = 4'd5;
      tick();
      inc_wr = 1'b0;
      chk("ch1_carry_ce", ce_out[1], 1);
      chk("ch1_carry_phase", phase_out[7:4], 0);
      chk("ch1_still_pend", pending, 2'b10);
      tick();
      chk("ch1_last_wins", phase_out[7:4], 2);
      tick(6);
      chk("ch1_pend_e31", pending, 2'b10);
      chk("ch1_phase_e31", phase_out[7:4], 14);
      tick();
      chk("ch1_carry2_ce", ce_out[1], 1);
      chk("ch1_pend_done", pending, 2'b00);

      // channel 0 to increment 3: spacing 6/5/5
      inc_wr = 1'b1; inc_sel = 1'b0; inc_data = 4'd3;
      tick();
      inc_wr = 1'b0;
      chk("ch1_inc5_phase", phase_out[7:4], 5);
      chk("ch0_phase_e33", phase_out[3:0], 10);
      chk("ch0_pend", pending, 2'b01);
      tick(3);
      chk("ch0_carry_e36", ce_out[0], 1);
      chk("ch0_applied", pending, 2'b00);
      for (int k = 37; k <= 58; k++) begin
         tick();
         chk("inc3_ce0", ce_out[0], (k == 42) || (k == 47) || (k == 52) || (k == 58));
         if (k <= 52) pulses += int'(ce_out[0]);
      end
      chk("inc3_pulses_16cyc", pulses, 3);

      // phase_clr with enable high, on a cycle where channel 1 would carry
      tick(2);
      phase_clr = 1'b1;
      tick();
      phase_clr = 1'b0;
      chk("clr_en_phase", phase_out, 0);
      chk("clr_en_ce", ce_out, 0);
      tick();
      chk("after_clr_phase", phase_out, 8'h53);
      chk("lock_before_stall", lock, 1);

      // phase_clr with enable low
      enable = 1'b0; phase_clr = 1'b1;
      tick();
      phase_clr = 1'b0;
      chk("clr_dis_phase", phase_out, 0);
      chk("clr_dis_ce", ce_out, 0);
      chk("clr_dis_lock", lock, 0);
      enable = 1'b1;
      tick(5);
      chk("run5_phase", phase_out, 8'h9F);
      chk("run5_lock", lock, 1);

      // enable low for 10 cycles; a write applies without waiting for a carry
      enable = 1'b0;
      for (int k = 69; k <= 78; k++) begin
         tick();
         chk("frz_phase", phase_out, 8'h9F);
         chk("frz_ce", ce_out, 0);
         chk("frz_lock", lock, 0);
         if (k == 71) chk("frz_pend_set", pending, 2'b01);
         if (k == 72) chk("frz_pend_applied", pending, 2'b00);
         if (k == 70) begin
            inc_wr = 1'b1; inc_sel = 1'b0; inc_data = 4'd1;
         end else begin
            inc_wr = 1'b0;
         end
      end
      enable = 1'b1;
      tick();
      chk("resume_ce", ce_out, 2'b01);
      chk("resume_phase", phase_out, 8'hE0);
      inc_wr = 1'b1; inc_sel = 1'b1; inc_data = 4'd7;
      tick();
      inc_wr = 1'b0;
      chk("pre_rst_ce", ce_out, 2'b10);
      chk("pre_rst_phase", phase_out, 8'h31);
      chk("pre_rst_pend", pending, 2'b10);

      // asynchronous reset while a pulse is high
      #3 reset_n = 1'b0;
      #1;
      chk("arst_ce", ce_out, 0);
      chk("arst_phase", phase_out, 0);
      chk("arst_pending", pending, 0);
      chk("arst_lock", lock, 0);
      tick();
      chk("arst_hold_phase", phase_out, 0);
      reset_n = 1'b1;
      tick();
      chk("post_rst_phase", phase_out, 8'h44);
      chk("post_rst_ce", ce_out, 0);
      tick(3);
      chk("post_rst_carry", ce_out, 2'b11);
      chk("post_rst_phase0", phase_out, 0);
      chk("post_rst_lock", lock, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/frac_clk_gen.md
FRAC_CLK_GEN -- requirements
Module: frac_clk_gen

Interface
REQ-001 SHALL have parameter CHANNELS, default 2: number of independent clock-enable channels (1..8).
REQ-002 SHALL have parameter ACC_WIDTH, default 32: phase accumulator width per channel (4..32).
REQ-003 SHALL have parameter PHASE_BITS, default 8: number of accumulator MSBs exported per channel (1..ACC_WIDTH).
REQ-004 SHALL have parameter DEFAULT_INC, default 32'h0000_0000: increment loaded into every channel at reset, truncated to ACC_WIDTH.
REQ-005 SHALL have parameter LOCK_CYCLES, default 16: enabled cycles without increment change before lock asserts (>=1).
REQ-006 SHALL have port clkin, input, 1: sole clock, rising edge.
REQ-007 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1: accumulators advance only when high.
REQ-009 SHALL have port phase_clr, input, 1: synchronous zeroing of all accumulators.
REQ-010 SHALL have port inc_wr, input, 1: single-cycle increment write strobe.
REQ-011 SHALL have port inc_sel, input, max(1,$clog2(CHANNELS)): target channel of inc_wr.
REQ-012 SHALL have port inc_data, input, ACC_WIDTH: new increment value.
REQ-013 SHALL have port ce_out, output, CHANNELS: one-cycle clock-enable pulse per channel.
REQ-014 SHALL have port phase_out, output, CHANNELS*PHASE_BITS: accumulator MSBs, channel 0 in LSBs.
REQ-015 SHALL have port pending, output, CHANNELS: channel has an unapplied increment.
REQ-016 SHALL have port lock, output, 1: all channels running at stable increments.

Function
REQ-017 SHALL per enabled cycle compute sum = acc + inc at ACC_WIDTH+1 bits; acc <= sum[ACC_WIDTH-1:0]; ce_out[i] <= sum[ACC_WIDTH] (registered, 1-cycle latency from the carrying add).
REQ-018 SHALL yield average ce_out[i] rate = inc/2^ACC_WIDTH of clkin; inc=0 gives no pulses.
REQ-019 SHALL drive phase_out from registered acc[ACC_WIDTH-1 -: PHASE_BITS], updated same edge as acc.
REQ-020 SHALL on inc_wr store inc_data into channel inc_sel's pending register and set pending[inc_sel]; inc_sel >= CHANNELS ignored.
REQ-021 SHALL apply a pending increment to the active increment on that channel's next carry cycle (the cycle sum[ACC_WIDTH]=1), clearing pending; the carrying add uses the old increment.
REQ-022 SHALL apply a pending increment on the next clock edge when the channel's active increment is 0 or enable is low.
REQ-023 SHALL let a second inc_wr to a still-pending channel overwrite the pending value (last write wins).
REQ-024 SHALL, when inc_wr hits a channel on its applying cycle, apply the old pending value and keep the new value pending.
REQ-025 SHALL, when phase_clr is high, set all acc to 0 and ce_out to 0 that edge, regardless of enable; pending increments apply per REQ-022 rule for enable low, else stay pending.
REQ-026 SHALL, when enable is low, hold acc, drive ce_out 0, and hold phase_out.
REQ-027 SHALL keep lock counter: cleared on reset, enable low, or any increment apply; increments while enable high; lock=1 when counter reaches LOCK_CYCLES, saturating.
REQ-028 SHALL hold lock low while any pending bit is set.
REQ-029 SHALL be synthesisable with no clock gating; ce_out is an enable, never used as a clock.

Reset
REQ-030 SHALL asynchronously on reset_n low set all acc=0, active inc=DEFAULT_INC, pending=0, ce_out=0, phase_out=0, lock=0, lock counter=0.
REQ-031 SHALL resume counting on the first rising clkin after reset_n deasserts; reset mid-pulse truncates the pulse immediately.

Verification
REQ-032 SHALL cover: ACC_WIDTH=4, inc=4, enable=1 -> ce_out[0] period exactly 4 cycles, phase_out stepping 0,4,8,12,0.
REQ-033 SHALL cover: ACC_WIDTH=4, inc=3 -> 3 pulses every 16 cycles, pulse spacing 5/5/6 repeating.
REQ-034 SHALL cover: inc=4 running, write 2 at acc=4 -> pending=1 until the carry into 0, old period completes, then period 8; lock low, reasserts after LOCK_CYCLES.
REQ-035 SHALL cover: two writes (6 then 2) to a pending channel before carry -> only 2 applied; write on applying cycle stays pending.
REQ-036 SHALL cover: phase_clr with enable=0 and enable=1 -> acc=0 next edge, no ce_out that cycle; enable low for 10 cycles -> acc frozen, lock drops.
REQ-037 SHALL cover: reset_n asserted asynchronously mid-run -> all outputs 0 without clock edge, inc reverts to DEFAULT_INC.
